// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI4 burst and response encodings plus the slave FSM states
package axi_pkg;
    typedef enum logic [1:0] {BURST_FIXED = 2'd0, BURST_INCR = 2'd1, BURST_WRAP = 2'd2} burst_e;
    localparam logic [1:0] RESP_OKAY = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_DELAY, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_DATA} r_state_e;
endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: next beat address, word index and legality of the current beat
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH = 8,
    parameter int MEM_DEPTH = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
)(
    input  logic [ADDR_WIDTH-1:0]        addr_i,
    input  logic [LEN_WIDTH-1:0]         len_i,
    input  logic [2:0]                   size_i,
    input  logic [1:0]                   burst_i,
    output logic [ADDR_WIDTH-1:0]        next_o,
    output logic [$clog2(MEM_DEPTH)-1:0] idx_o,
    output logic                         legal_o
);
    localparam int LOG2B = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    logic [ADDR_WIDTH-1:0] incr, mask, word;
    logic [ADDR_WIDTH:0] diff;
    logic wrap_len_ok, burst_err, range_err;
    always_comb begin
        incr = ADDR_WIDTH'(1) << size_i;
        mask = (ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) * incr - ADDR_WIDTH'(1);
        next_o = burst_i == BURST_FIXED ? addr_i
               : burst_i == BURST_WRAP ? (addr_i & ~mask) | ((addr_i + incr) & mask)
               : addr_i + incr;
        wrap_len_ok = len_i == LEN_WIDTH'(1) || len_i == LEN_WIDTH'(3)
                   || len_i == LEN_WIDTH'(7) || len_i == LEN_WIDTH'(15);
        burst_err = burst_i == 2'd3 || size_i > 3'(LOG2B) || (burst_i == BURST_WRAP && !wrap_len_ok);
        // the borrow bit flags addresses below the base
        diff = {1'b0, addr_i} - {1'b0, BASE_ADDR};
        word = diff[ADDR_WIDTH-1:0] >> LOG2B;
        range_err = diff[ADDR_WIDTH] || word >= ADDR_WIDTH'(MEM_DEPTH);
        idx_o = IDX_W'(word);
        legal_o = !burst_err && !range_err;
    end
endmodule

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI4 slave memory, FIXED/INCR/WRAP bursts, byte strobes,
// programmable response delay and SLVERR on illegal beats; one burst per direction.
module axi_slave_mem
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH = 4,
    parameter int LEN_WIDTH = 8,
    parameter int MEM_DEPTH = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int RESP_DELAY = 0
)(
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [LEN_WIDTH-1:0]    AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [LEN_WIDTH-1:0]    ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int DLY_W = RESP_DELAY > 0 ? $clog2(RESP_DELAY + 1) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(RESP_DELAY - 1);
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic rdy_q;
    w_state_e w_state_q, w_state_d;
    logic [ID_WIDTH-1:0] aw_id_q, aw_id_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d, w_next;
    logic [LEN_WIDTH-1:0] aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
    logic [2:0] aw_size_q, aw_size_d;
    logic [1:0] aw_burst_q, aw_burst_d;
    logic w_err_q, w_err_d, w_ok, w_hs, w_last;
    logic [DLY_W-1:0] w_dly_q, w_dly_d;
    logic [IDX_W-1:0] w_idx;
    r_state_e r_state_q, r_state_d;
    logic [ID_WIDTH-1:0] ar_id_q, ar_id_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d, r_next;
    logic [LEN_WIDTH-1:0] ar_len_q, ar_len_d, r_cnt_q, r_cnt_d;
    logic [2:0] ar_size_q, ar_size_d;
    logic [1:0] ar_burst_q, ar_burst_d;
    logic [DLY_W-1:0] r_dly_q, r_dly_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0] rresp_q, rresp_d;
    logic [IDX_W-1:0] r_idx;
    logic r_ok, r_idle, ar_hs, r_hs, r_fetch;

    assign AWREADY = rdy_q && w_state_q == W_IDLE;
    assign WREADY = w_state_q == W_DATA;
    assign BVALID = w_state_q == W_RESP;
    assign BID = aw_id_q;
    assign BRESP = w_err_q ? RESP_SLVERR : RESP_OKAY;
    assign w_hs = WREADY && WVALID;
    assign w_last = w_cnt_q == aw_len_q;

    axi_burst_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH),
        .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)
    ) u_wgen (
        .addr_i(w_addr_q), .len_i(aw_len_q), .size_i(aw_size_q), .burst_i(aw_burst_q),
        .next_o(w_next), .idx_o(w_idx), .legal_o(w_ok)
    );

    always_comb begin
        w_state_d = w_state_q;
        aw_id_d = aw_id_q;
        aw_len_d = aw_len_q;
        aw_size_d = aw_size_q;
        aw_burst_d = aw_burst_q;
        w_addr_d = w_hs ? w_next : w_addr_q;
        w_cnt_d = w_hs ? w_cnt_q + LEN_WIDTH'(1) : w_cnt_q;
        w_err_d = w_err_q || (w_hs && (!w_ok || WLAST != w_last));
        w_dly_d = w_state_q == W_DELAY ? w_dly_q + DLY_W'(1) : '0;
        case (w_state_q)
            W_IDLE: if (AWREADY && AWVALID) begin
                aw_id_d = AWID;
                aw_len_d = AWLEN;
                aw_size_d = AWSIZE;
                aw_burst_d = AWBURST;
                w_addr_d = AWADDR;
                w_cnt_d = '0;
                w_err_d = 1'b0;
                w_state_d = W_DATA;
            end
            W_DATA: if (w_hs && w_last) w_state_d = RESP_DELAY > 0 ? W_DELAY : W_RESP;
            W_DELAY: if (w_dly_q == DLY_LAST) w_state_d = W_RESP;
            W_RESP: if (BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    assign r_idle = r_state_q == R_IDLE;
    assign ARREADY = rdy_q && r_idle;
    assign RVALID = r_state_q == R_DATA;
    assign RLAST = RVALID && r_cnt_q == ar_len_q;
    assign RID = ar_id_q;
    assign RDATA = rdata_q;
    assign RRESP = rresp_q;
    assign ar_hs = ARREADY && ARVALID;
    assign r_hs = RVALID && RREADY;
    // r_addr_q runs one beat ahead: it is the next address to fetch into rdata_q
    assign r_fetch = (ar_hs && RESP_DELAY == 0) || (r_state_q == R_DELAY && r_dly_q == DLY_LAST)
                  || (r_hs && !RLAST);

    axi_burst_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH),
        .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)
    ) u_rgen (
        .addr_i(r_idle ? ARADDR : r_addr_q), .len_i(r_idle ? ARLEN : ar_len_q),
        .size_i(r_idle ? ARSIZE : ar_size_q), .burst_i(r_idle ? ARBURST : ar_burst_q),
        .next_o(r_next), .idx_o(r_idx), .legal_o(r_ok)
    );

    always_comb begin
        r_state_d = r_state_q;
        ar_id_d = ar_id_q;
        ar_len_d = ar_len_q;
        ar_size_d = ar_size_q;
        ar_burst_d = ar_burst_q;
        r_addr_d = r_fetch ? r_next : r_addr_q;
        rdata_d = r_fetch ? (r_ok ? mem_q[r_idx] : '0) : rdata_q;
        rresp_d = r_fetch ? (r_ok ? RESP_OKAY : RESP_SLVERR) : rresp_q;
        r_cnt_d = r_hs ? r_cnt_q + LEN_WIDTH'(1) : r_cnt_q;
        r_dly_d = r_state_q == R_DELAY ? r_dly_q + DLY_W'(1) : '0;
        case (r_state_q)
            R_IDLE: if (ar_hs) begin
                ar_id_d = ARID;
                ar_len_d = ARLEN;
                ar_size_d = ARSIZE;
                ar_burst_d = ARBURST;
                r_cnt_d = '0;
                r_addr_d = RESP_DELAY > 0 ? ARADDR : r_next;
                r_state_d = RESP_DELAY > 0 ? R_DELAY : R_DATA;
            end
            R_DELAY: if (r_dly_q == DLY_LAST) r_state_d = R_DATA;
            R_DATA: if (r_hs && RLAST) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rdy_q <= 1'b0;
            w_state_q <= W_IDLE;
            aw_id_q <= '0;
            aw_len_q <= '0;
            aw_size_q <= '0;
            aw_burst_q <= '0;
            w_addr_q <= '0;
            w_cnt_q <= '0;
            w_err_q <= 1'b0;
            w_dly_q <= '0;
            r_state_q <= R_IDLE;
            ar_id_q <= '0;
            ar_len_q <= '0;
            ar_size_q <= '0;
            ar_burst_q <= '0;
            r_addr_q <= '0;
            r_cnt_q <= '0;
            r_dly_q <= '0;
            rdata_q <= '0;
            rresp_q <= '0;
        end else begin
            rdy_q <= 1'b1;
            w_state_q <= w_state_d;
            aw_id_q <= aw_id_d;
            aw_len_q <= aw_len_d;
            aw_size_q <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            w_addr_q <= w_addr_d;
            w_cnt_q <= w_cnt_d;
            w_err_q <= w_err_d;
            w_dly_q <= w_dly_d;
            r_state_q <= r_state_d;
            ar_id_q <= ar_id_d;
            ar_len_q <= ar_len_d;
            ar_size_q <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            r_addr_q <= r_addr_d;
            r_cnt_q <= r_cnt_d;
            r_dly_q <= r_dly_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_hs && w_ok)
            for (int b = 0; b < DATA_WIDTH / 8; b++)
                if (WSTRB[b]) mem_q[w_idx][b*8 +: 8] <= WDATA[b*8 +: 8];
    end
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: directed AXI4 bursts against axi_slave_mem with hand-computed expectations
module tb_axi_slave_mem;
    localparam int DLY = 3;
    logic ACLK = 1'b0, ARESETn = 1'b0;
    logic [3:0] AWID = '0, ARID = '0, BID, RID;
    logic [31:0] AWADDR = '0, ARADDR = '0, WDATA = '0, RDATA;
    logic [7:0] AWLEN = '0, ARLEN = '0;
    logic [2:0] AWSIZE = '0, ARSIZE = '0;
    logic [1:0] AWBURST = '0, ARBURST = '0, BRESP, RRESP;
    logic [3:0] WSTRB = '0;
    logic AWVALID = 1'b0, WLAST = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
    logic AWREADY, WREADY, BVALID, ARREADY, RLAST, RVALID;
    int errs = 0, checks = 0, lat;

    always #5 ACLK = ~ACLK;

    axi_slave_mem #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(8),
        .MEM_DEPTH(1024), .RESP_DELAY(DLY)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                           input logic [2:0] s, input logic [1:0] bt);
        int n = 0;
        @(negedge ACLK);
        AWID = id; AWADDR = a; AWLEN = l; AWSIZE = s; AWBURST = bt; AWVALID = 1'b1;
        while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
        chk("aw_ready", AWREADY, 1);
        @(negedge ACLK);
        AWVALID = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                           input logic [2:0] s, input logic [1:0] bt);
        int n = 0;
        @(negedge ACLK);
        ARID = id; ARADDR = a; ARLEN = l; ARSIZE = s; ARBURST = bt; ARVALID = 1'b1;
        while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
        chk("ar_ready", ARREADY, 1);
        @(negedge ACLK);
        ARVALID = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] st, input logic la);
        int n = 0;
        @(negedge ACLK);
        WDATA = d; WSTRB = st; WLAST = la; WVALID = 1'b1;
        while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
        chk("w_ready", WREADY, 1);
        @(negedge ACLK);
        WVALID = 1'b0;
    endtask

    task automatic b_recv(input string tag, input logic [3:0] id, input logic [1:0] rs, input int stall);
        int n = 0;
        while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
        chk({tag, "_bvalid"}, BVALID, 1);
        repeat (stall) begin
            chk({tag, "_bhold"}, {BVALID, BID, BRESP}, {1'b1, id, rs});
            @(negedge ACLK);
        end
        chk({tag, "_bid"}, BID, id);
        chk({tag, "_bresp"}, BRESP, rs);
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
    endtask

    task automatic r_beat(input string tag, input logic [31:0] d, input logic [1:0] rs,
                          input logic la, input logic [3:0] id, input int stall);
        int n = 0;
        while (!RVALID && n < 50) begin @(negedge ACLK); n++; end
        chk({tag, "_rvalid"}, RVALID, 1);
        repeat (stall) begin
            chk({tag, "_rhold"}, {RVALID, RID, RDATA, RRESP, RLAST}, {1'b1, id, d, rs, la});
            @(negedge ACLK);
        end
        chk({tag, "_rdata"}, RDATA, d);
        chk({tag, "_rresp"}, RRESP, rs);
        chk({tag, "_rlast"}, RLAST, la);
        chk({tag, "_rid"}, RID, id);
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge ACLK);
        chk("rst_outs", {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, BRESP, RRESP, BID, RID, RDATA}, 0);
        ARESETn = 1'b1;
        #1 chk("rel_ready0", {AWREADY, ARREADY}, 2'b00);
        @(negedge ACLK);
        chk("rel_ready1", {AWREADY, ARREADY}, 2'b11);

        aw_send(4'h3, 32'h10, 8'd3, 3'd2, 2'd1);
        for (int i = 0; i < 4; i++) w_send(32'hA0 + i, 4'hF, i == 3);
        b_recv("t1", 4'h3, 2'd0, 0);
        chk("t1_bdone", BVALID, 0);
        ar_send(4'h5, 32'h10, 8'd3, 3'd2, 2'd1);
        for (int i = 0; i < 4; i++) r_beat("t1", 32'hA0 + i, 2'd0, i == 3, 4'h5, 0);
        chk("t1_rdone", RVALID, 0);

        aw_send(4'h1, 32'h38, 8'd3, 3'd2, 2'd2);
        for (int i = 0; i < 4; i++) w_send(32'hD000_0000 + i, 4'hF, i == 3);
        b_recv("t2", 4'h1, 2'd0, 0);
        ar_send(4'h2, 32'h30, 8'd3, 3'd2, 2'd1);
        for (int i = 0; i < 4; i++) r_beat("t2i", 32'hD000_0000 + ((i + 2) % 4), 2'd0, i == 3, 4'h2, 0);
        ar_send(4'h2, 32'h38, 8'd3, 3'd2, 2'd2);
        for (int i = 0; i < 4; i++) r_beat("t2w", 32'hD000_0000 + i, 2'd0, i == 3, 4'h2, 0);

        aw_send(4'h0, 32'h0, 8'd0, 3'd2, 2'd1);
        w_send(32'hFFFF_FFFF, 4'hF, 1'b1);
        b_recv("t3a", 4'h0, 2'd0, 0);
        aw_send(4'h0, 32'h0, 8'd0, 3'd2, 2'd1);
        w_send(32'h1234_5678, 4'b0101, 1'b1);
        b_recv("t3b", 4'h0, 2'd0, 0);
        ar_send(4'h0, 32'h0, 8'd0, 3'd2, 2'd1);
        r_beat("t3", 32'hFF34_FF78, 2'd0, 1'b1, 4'h0, 0);

        aw_send(4'h7, 32'hFFC, 8'd1, 3'd2, 2'd1);
        w_send(32'h1111_1111, 4'hF, 1'b0);
        w_send(32'h2222_2222, 4'hF, 1'b1);
        b_recv("t4", 4'h7, 2'd2, 0);
        ar_send(4'h7, 32'hFFC, 8'd1, 3'd2, 2'd1);
        r_beat("t4b0", 32'h1111_1111, 2'd0, 1'b0, 4'h7, 0);
        r_beat("t4b1", 32'h0, 2'd2, 1'b1, 4'h7, 0);

        aw_send(4'h4, 32'h100, 8'd1, 3'd2, 2'd1);
        w_send(32'hB0, 4'hF, 1'b0);
        w_send(32'hB1, 4'hF, 1'b1);
        lat = 1;
        while (!BVALID && lat < 50) begin @(negedge ACLK); lat++; end
        chk("t5_b_lat", lat, 1 + DLY);
        b_recv("t5", 4'h4, 2'd0, 5);
        ar_send(4'h4, 32'h100, 8'd1, 3'd2, 2'd1);
        lat = 1;
        while (!RVALID && lat < 50) begin @(negedge ACLK); lat++; end
        chk("t5_r_lat", lat, 1 + DLY);
        r_beat("t5b0", 32'hB0, 2'd0, 1'b0, 4'h4, 3);
        r_beat("t5b1", 32'hB1, 2'd0, 1'b1, 4'h4, 2);

        aw_send(4'h9, 32'h20, 8'd1, 3'd2, 2'd1);
        w_send(32'hC0, 4'hF, 1'b1);
        w_send(32'hC1, 4'hF, 1'b1);
        b_recv("wlast", 4'h9, 2'd2, 0);
        ar_send(4'h9, 32'h20, 8'd1, 3'd2, 2'd1);
        r_beat("wlast0", 32'hC0, 2'd0, 1'b0, 4'h9, 0);
        r_beat("wlast1", 32'hC1, 2'd0, 1'b1, 4'h9, 0);

        aw_send(4'h8, 32'h10, 8'd0, 3'd2, 2'd3);
        w_send(32'hDEAD_BEEF, 4'hF, 1'b1);
        b_recv("bt3", 4'h8, 2'd2, 0);
        ar_send(4'h8, 32'h10, 8'd0, 3'd2, 2'd1);
        r_beat("bt3_keep", 32'hA0, 2'd0, 1'b1, 4'h8, 0);
        ar_send(4'hA, 32'h10, 8'd2, 3'd2, 2'd2);
        for (int i = 0; i < 3; i++) r_beat("badwrap", 32'h0, 2'd2, i == 2, 4'hA, 0);
        ar_send(4'hB, 32'h10, 8'd0, 3'd3, 2'd1);
        r_beat("badsize", 32'h0, 2'd2, 1'b1, 4'hB, 0);

        aw_send(4'h6, 32'h200, 8'd3, 3'd2, 2'd1);
        w_send(32'hE0, 4'hF, 1'b0);
        w_send(32'hE1, 4'hF, 1'b0);
        chk("t6_mid_wready", WREADY, 1);
        ARESETn = 1'b0;
        #1 chk("t6_rst_outs", {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, BRESP, RRESP, BID, RID, RDATA}, 0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1 chk("t6_rel_awready0", AWREADY, 0);
        @(negedge ACLK);
        chk("t6_rel_awready1", AWREADY, 1);
        aw_send(4'h6, 32'h300, 8'd1, 3'd2, 2'd1);
        w_send(32'hF0, 4'hF, 1'b0);
        w_send(32'hF1, 4'hF, 1'b1);
        b_recv("t6", 4'h6, 2'd0, 0);
        ar_send(4'h6, 32'h200, 8'd1, 3'd2, 2'd1);
        r_beat("t6b0", 32'hE0, 2'd0, 1'b0, 4'h6, 0);
        r_beat("t6b1", 32'hE1, 2'd0, 1'b1, 4'h6, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
